// File: rtl/ram_sync_dp_clr.sv
// ----------------------------------------------------------------------------
// ram_sync_dp_clr
//
// Synchronous simple-dual-port RAM: one write port and one registered read
// port on a single clock. After every reset the array is walked once and
// zeroed, one word per clock. Requests are dropped while that runs.
//
// Parameters:
//   DATA_W   - data word width in bits (>= 1)
//   ADDR_W   - address width; depth is 2**ADDR_W words
//   RDW_MODE - same-address read-during-write result:
//              0 = read-old (pre-write contents), 1 = write-first (wr_data)
//
// Ports:
//   clk        - clock, all activity on the rising edge
//   rst_n      - synchronous reset, active low
//   wr_en      - write request
//   wr_addr    - write address
//   wr_data    - write data
//   rd_en      - read request
//   rd_addr    - read address
//   rd_data    - registered read data, holds its last value between reads
//   rd_valid   - one-cycle strobe, rd_data was updated by the last edge
//   busy       - high while the post-reset clear sequence runs
//   err_inj    - inverts the stored parity bit of a write (parity build only)
//   rd_par_err - parity mismatch flag, registered alongside rd_data
//
// Optional build macro:
//   RAM_SYNC_DP_PARITY_EN - store one parity bit per word and check it on
//                           reads. Without it no parity storage exists,
//                           err_inj is unused and rd_par_err is held at 0.
//                           The port list is the same in both builds.
// ----------------------------------------------------------------------------
module ram_sync_dp_clr #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  input  logic              err_inj,
  output logic              rd_par_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_last;
  logic              wr_fire;
  logic              rd_fire;
  logic              rdw_bypass;

  logic [DATA_W-1:0] mem [DEPTH];

  // The clear finishes on the edge that zeroes the top address, which is
  // the all-ones pointer value.
  assign clr_last = &clr_ptr;

  // Requests only take effect once the array has been cleared.
  assign wr_fire = (state == ST_READY) && wr_en;
  assign rd_fire = (state == ST_READY) && rd_en;

  // Write-first mode forwards the incoming word when both ports hit the
  // same address on the same edge; read-old mode simply reads the array,
  // which still holds the pre-write value at that edge.
  assign rdw_bypass = (RDW_MODE == 1) && wr_fire && (wr_addr == rd_addr);

  // State register. Reset always restarts the clear, even from the middle
  // of a clear already in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and busy decode. busy follows the state register directly,
  // so it rises on the reset edge and falls on the edge that clears the
  // last address.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_last) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_CLEAR;
        busy       = 1'b1;
      end
    endcase
  end

  // Clear pointer. It walks every address exactly once per clear and wraps
  // back to 0, which is where the next clear must start anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  // Storage array. The clear sequence owns the write port while it runs;
  // nothing is written on a reset edge so the clear restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_fire) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Registered read port. A reset discards any read in flight. rd_data
  // keeps its last value when no read is accepted; only rd_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_fire) begin
      rd_valid <= 1'b1;
      if (rdw_bypass) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

`ifdef RAM_SYNC_DP_PARITY_EN

  logic mem_par [DEPTH];

  // Parity storage, written in lockstep with the data array. A cleared
  // word has data 0 and parity 0, which is consistent. err_inj flips the
  // stored bit so a later read reports a mismatch.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem_par[clr_ptr] <= 1'b0;
      end else if (wr_fire) begin
        mem_par[wr_addr] <= (^wr_data) ^ err_inj;
      end
    end
  end

  // Parity check, registered with rd_data and only meaningful with
  // rd_valid. On the write-first bypass the checked parity would be
  // ^wr_data ^ err_inj against data wr_data, so the mismatch reduces to
  // err_inj itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_par_err <= 1'b0;
    end else if (rd_fire) begin
      if (rdw_bypass) begin
        rd_par_err <= err_inj;
      end else begin
        rd_par_err <= (^mem[rd_addr]) ^ mem_par[rd_addr];
      end
    end else begin
      rd_par_err <= 1'b0;
    end
  end

`else

  logic unused_err_inj;

  // Without parity storage there is nothing to check; err_inj is
  // deliberately left unconnected to any logic.
  assign unused_err_inj = err_inj;
  assign rd_par_err     = 1'b0;

`endif

endmodule

// File: tb/tb_ram_sync_dp_clr.sv
// ----------------------------------------------------------------------------
// tb_ram_sync_dp_clr
//
// Directed self-checking bench for ram_sync_dp_clr with default sizes
// (8-bit data, 16 words). RDW_MODE below selects the read-during-write
// expectation; RAM_SYNC_DP_PARITY_EN selects the parity expectations.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at that same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_ram_sync_dp_clr;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int RDW_MODE = 0;
  localparam int BUSY_MAX = 40;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              err_inj;
  logic              rd_par_err;

  int tests_run;
  int failed;

  ram_sync_dp_clr #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RDW_MODE(RDW_MODE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .err_inj   (err_inj),
    .rd_par_err(rd_par_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every request input in one step.
  task automatic apply_stimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic re,
                                input logic [ADDR_W-1:0] ra, input logic ei);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    err_inj = ei;
  endtask

  // One counted comparison.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Count edges from reset release until busy drops, checking that no
  // read strobe ever appears meanwhile.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (n < BUSY_MAX) begin
      tick();
      n++;
      check_output({tag, "_valid_in_busy"}, 32'(rd_valid), 32'd0);
      if (!busy) break;
    end
    check_output({tag, "_busy_edges"}, 32'(n), 32'(DEPTH));
  endtask

  // Read every address on consecutive cycles and expect zero.
  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b0);
      tick();
      check_output({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check_output({tag, "_data"}, 32'(rd_data), 32'd0);
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    rst_n     = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);

    // Reset held for two edges.
    tick();
    tick();
    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_valid", 32'(rd_valid), 32'd0);
    check_output("rst_data", 32'(rd_data), 32'd0);
    check_output("rst_par_err", 32'(rd_par_err), 32'd0);

    // Release reset while hammering a write of 55 to address 3 and a read;
    // both must be dropped for the whole clear.
    apply_stimulus(1'b1, 4'd3, 8'h55, 1'b1, 4'd3, 1'b0);
    rst_n = 1'b1;
    count_busy("clr1");
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    read_all_zero("zero1");

    // Fill with A0+i, then read back on every cycle.
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, ADDR_W'(i), 8'hA0 + DATA_W'(i), 1'b0, '0, 1'b0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b0);
      tick();
      check_output("wr_rd_valid", 32'(rd_valid), 32'd1);
      check_output("wr_rd_data", 32'(rd_data), 32'(8'hA0 + DATA_W'(i)));
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    check_output("idle_valid", 32'(rd_valid), 32'd0);
    check_output("idle_hold", 32'(rd_data), 32'h000000AF);

    // Simultaneous write and read to different addresses.
    apply_stimulus(1'b1, 4'd2, 8'h3C, 1'b1, 4'd9, 1'b0);
    tick();
    check_output("diff_rd", 32'(rd_data), 32'h000000A9);
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b0);
    tick();
    check_output("diff_wr", 32'(rd_data), 32'h0000003C);

    // Read-during-write on address 5: old 11, new 22.
    apply_stimulus(1'b1, 4'd5, 8'h11, 1'b0, '0, 1'b0);
    tick();
    apply_stimulus(1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 1'b0);
    tick();
    check_output("rdw_valid", 32'(rd_valid), 32'd1);
    check_output("rdw_data", 32'(rd_data), (RDW_MODE == 1) ? 32'h22 : 32'h11);
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'd5, 1'b0);
    tick();
    check_output("rdw_after", 32'(rd_data), 32'h00000022);

    // Parity: corrupted write, then clean rewrite of address 7.
    apply_stimulus(1'b1, 4'd7, 8'h5B, 1'b0, '0, 1'b1);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'd7, 1'b0);
    tick();
    check_output("par_valid", 32'(rd_valid), 32'd1);
    check_output("par_data", 32'(rd_data), 32'h0000005B);
`ifdef RAM_SYNC_DP_PARITY_EN
    check_output("par_err_inj", 32'(rd_par_err), 32'd1);
`else
    check_output("par_err_inj", 32'(rd_par_err), 32'd0);
`endif
    apply_stimulus(1'b1, 4'd7, 8'h5B, 1'b0, '0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'd7, 1'b0);
    tick();
    check_output("par_err_clean", 32'(rd_par_err), 32'd0);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    check_output("par_err_idle", 32'(rd_par_err), 32'd0);

    // Same-address write with injection while reading address 7: the
    // bypass path flags the injected error, read-old sees the clean word.
    apply_stimulus(1'b1, 4'd7, 8'h0F, 1'b1, 4'd7, 1'b1);
    tick();
`ifdef RAM_SYNC_DP_PARITY_EN
    check_output("par_rdw", 32'(rd_par_err), (RDW_MODE == 1) ? 32'd1 : 32'd0);
`else
    check_output("par_rdw", 32'(rd_par_err), 32'd0);
`endif
    check_output("par_rdw_data", 32'(rd_data), (RDW_MODE == 1) ? 32'h0F : 32'h5B);

    // Reset with a read in flight, then reset again at the clear midpoint.
    apply_stimulus(1'b0, '0, '0, 1'b1, 4'd9, 1'b0);
    rst_n = 1'b0;
    tick();
    check_output("mid_rst_valid", 32'(rd_valid), 32'd0);
    check_output("mid_rst_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH / 2; i++) begin
      tick();
    end
    check_output("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_output("mid_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    count_busy("clr2");
    read_all_zero("zero2");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
